// File: rtl/conv_fm_sequencer.sv
// conv_fm_sequencer: holds one feature map, streams it into the conv PE,
// then collects the rectified results into a host-readable buffer.
module conv_fm_sequencer #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE = 3,
  parameter int PADDING = 0,
  parameter int STRIDE = 1,
  parameter int DATA_W = 30,
  parameter int RES_W = 48,
  parameter int TIMEOUT = 64,
  localparam int OUT_SIZE =
    (FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE+1,
  localparam int N_OUT = OUT_SIZE*OUT_SIZE,
  localparam int N_PIX = FM_SIZE*FM_SIZE,
  localparam int PA_W = (N_PIX > 1) ? $clog2(N_PIX) : 1,
  localparam int RA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_en,
  input  logic [PA_W-1:0]   i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_start,
  output logic [DATA_W-1:0] o_DataFM,
  output logic              o_en,
  input  logic              i_res_en,
  input  logic [RES_W-1:0]  i_res_data,
  input  logic [RA_W-1:0]   i_rd_addr,
  output logic [RES_W-1:0]  o_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int TM_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [PA_W-1:0] PIX_LAST = PA_W'(N_PIX-1);
  localparam logic [PA_W:0]   PIX_LIM  = (PA_W+1)'(N_PIX);
  localparam logic [RA_W:0]   RES_FULL = (RA_W+1)'(N_OUT);
  localparam logic [TM_W-1:0] TMO_LAST = TM_W'(TIMEOUT-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PA_W-1:0]   pix_cnt;
  logic [RA_W:0]     res_cnt;
  logic [TM_W-1:0]   tmo_cnt;
  logic              err_q;
  logic [RES_W-1:0]  rd_q;

  logic [DATA_W-1:0] pixbuf [N_PIX];
  logic [RES_W-1:0]  resbuf [N_OUT];

  logic idle;
  logic busy;
  logic res_full;
  logic start_go;
  logic load_go;
  logic cap_go;
  logic tmo_hit;
  logic rd_ok;

  assign idle     = (state == S_IDLE);
  assign busy     = (state == S_STREAM) ||
                    (state == S_DRAIN);
  assign res_full = (res_cnt == RES_FULL);
  assign start_go = idle && i_start;
  assign load_go  = idle && i_load_en && !i_rst &&
                    ({1'b0, i_load_addr} < PIX_LIM);
  assign cap_go   = busy && i_res_en && !res_full;
  assign rd_ok    = ({1'b0, i_rd_addr} < RES_FULL);

  always_comb begin
    state_nx = state;
    tmo_hit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start)
          state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (pix_cnt == PIX_LAST)
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_full) begin
          state_nx = S_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = S_DONE;
          tmo_hit  = 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      pix_cnt <= '0;
      res_cnt <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_go) begin
        pix_cnt <= '0;
        res_cnt <= '0;
        tmo_cnt <= '0;
        err_q   <= 1'b0;
      end else begin
        if (state == S_STREAM)
          pix_cnt <= pix_cnt + 1'b1;
        if (state == S_DRAIN)
          tmo_cnt <= tmo_cnt + 1'b1;
        if (cap_go)
          res_cnt <= res_cnt + 1'b1;
        if (tmo_hit)
          err_q <= 1'b1;
      end
    end
  end

  // buffers survive reset; only the write strobes are gated by it
  always_ff @(posedge i_clk) begin
    if (load_go)
      pixbuf[i_load_addr] <= i_load_data;
    if (cap_go && !i_rst)
      resbuf[res_cnt[RA_W-1:0]] <= i_res_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      rd_q <= '0;
    else if (rd_ok)
      rd_q <= resbuf[i_rd_addr];
    else
      rd_q <= '0;
  end

  assign o_en      = busy;
  assign o_busy    = busy;
  assign o_done    = (state == S_DONE);
  assign o_err     = err_q;
  assign o_rd_data = rd_q;
  assign o_DataFM  = (state == S_STREAM) ?
                     pixbuf[pix_cnt] : '0;

endmodule
